// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - IFU/LSU request-response and memory data port bundle
interface mem_bus_arbiter_if;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_resp_valid;
  logic        ifu_resp_ready;
  logic [31:0] ifu_resp_data;
  logic        ifu_resp_err;

  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic        lsu_req_wen;
  logic [2:0]  lsu_req_rwtyp;
  logic [31:0] lsu_req_addr;
  logic [31:0] lsu_req_wdata;
  logic        lsu_resp_valid;
  logic        lsu_resp_ready;
  logic [31:0] lsu_resp_rdata;
  logic        lsu_resp_err;

  logic        mem_bus_wen;
  logic [2:0]  mem_bus_rwtyp;
  logic [31:0] mem_bus_addr;
  logic [31:0] mem_bus_wdata;
  logic [31:0] mem_bus_rdata;

  modport slave (
    input  ifu_req_valid, ifu_req_addr, ifu_resp_ready,
    input  lsu_req_valid, lsu_req_wen, lsu_req_rwtyp, lsu_req_addr, lsu_req_wdata, lsu_resp_ready,
    input  mem_bus_rdata,
    output ifu_req_ready, ifu_resp_valid, ifu_resp_data, ifu_resp_err,
    output lsu_req_ready, lsu_resp_valid, lsu_resp_rdata, lsu_resp_err,
    output mem_bus_wen, mem_bus_rwtyp, mem_bus_addr, mem_bus_wdata
  );

  modport master (
    output ifu_req_valid, ifu_req_addr, ifu_resp_ready,
    output lsu_req_valid, lsu_req_wen, lsu_req_rwtyp, lsu_req_addr, lsu_req_wdata, lsu_resp_ready,
    output mem_bus_rdata,
    input  ifu_req_ready, ifu_resp_valid, ifu_resp_data, ifu_resp_err,
    input  lsu_req_ready, lsu_resp_valid, lsu_resp_rdata, lsu_resp_err,
    input  mem_bus_wen, mem_bus_rwtyp, mem_bus_addr, mem_bus_wdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin IFU/LSU arbiter for a single-port memory
module mem_bus_arbiter (
  input  logic             clk,
  input  logic             rstn,
  mem_bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t      state, state_nxt;
  logic        prio_ifu;
  logic        own_ifu;
  logic        req_wen;
  logic [2:0]  req_rwtyp;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] resp_data;
  logic        resp_err;

  logic        grant_ifu, grant_lsu, accept, misaligned;
  logic        in_wen;
  logic [2:0]  in_rwtyp;
  logic [31:0] in_addr, in_wdata;
  logic [31:0] load_data;
  logic        resp_hs;

  // prio_ifu only breaks ties; a lone requester always wins
  always_comb begin
    grant_ifu = bus.ifu_req_valid && (!bus.lsu_req_valid || prio_ifu);
    grant_lsu = bus.lsu_req_valid && !grant_ifu;
    accept    = (state == IDLE) && (grant_ifu || grant_lsu);
    in_rwtyp  = grant_ifu ? 3'b010 : bus.lsu_req_rwtyp;
    in_addr   = grant_ifu ? bus.ifu_req_addr : bus.lsu_req_addr;
    in_wen    = grant_ifu ? 1'b0 : bus.lsu_req_wen;
    in_wdata  = grant_ifu ? 32'd0 : bus.lsu_req_wdata;
    misaligned = (in_rwtyp[1:0] == 2'b11) ||
                 ((in_rwtyp[1:0] == 2'b01) && in_addr[0]) ||
                 ((in_rwtyp[1:0] == 2'b10) && (in_addr[1:0] != 2'b00));
  end

  // memory returns LSB-aligned data; upper bits are replaced by the extension
  always_comb begin
    load_data = bus.mem_bus_rdata;
    case (req_rwtyp[1:0])
      2'b00:   load_data = {{24{!req_rwtyp[2] && bus.mem_bus_rdata[7]}}, bus.mem_bus_rdata[7:0]};
      2'b01:   load_data = {{16{!req_rwtyp[2] && bus.mem_bus_rdata[15]}}, bus.mem_bus_rdata[15:0]};
      default: load_data = bus.mem_bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    resp_hs   = 1'b0;
    case (state)
      IDLE:    if (accept) state_nxt = misaligned ? RESP : ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP: begin
        resp_hs = own_ifu ? bus.ifu_resp_ready : bus.lsu_resp_ready;
        if (resp_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    bus.ifu_req_ready  = (state == IDLE) && grant_ifu;
    bus.lsu_req_ready  = (state == IDLE) && grant_lsu;
    bus.ifu_resp_valid = (state == RESP) && own_ifu;
    bus.lsu_resp_valid = (state == RESP) && !own_ifu;
    bus.ifu_resp_data  = bus.ifu_resp_valid ? resp_data : 32'd0;
    bus.ifu_resp_err   = bus.ifu_resp_valid && resp_err;
    bus.lsu_resp_rdata = bus.lsu_resp_valid ? resp_data : 32'd0;
    bus.lsu_resp_err   = bus.lsu_resp_valid && resp_err;
    bus.mem_bus_wen    = (state == ACCESS) && req_wen;
  end

  assign bus.mem_bus_rwtyp = req_rwtyp;
  assign bus.mem_bus_addr  = req_addr;
  assign bus.mem_bus_wdata = req_wdata;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prio_ifu  <= 1'b0;
      own_ifu   <= 1'b0;
      req_wen   <= 1'b0;
      req_rwtyp <= 3'd0;
      req_addr  <= 32'd0;
      req_wdata <= 32'd0;
      resp_data <= 32'd0;
      resp_err  <= 1'b0;
    end else if (accept) begin
      own_ifu   <= grant_ifu;
      prio_ifu  <= !grant_ifu;
      req_wen   <= in_wen;
      req_rwtyp <= in_rwtyp;
      req_addr  <= in_addr;
      req_wdata <= in_wdata;
      resp_err  <= misaligned;
      resp_data <= 32'd0;
    end else if (state == ACCESS) begin
      resp_data <= req_wen ? 32'd0 : load_data;
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  mem_bus_arbiter_if bus();
  mem_bus_arbiter dut (.clk(clk), .rstn(rstn), .bus(bus));

  typedef struct {
    logic        is_ifu;
    logic        err;
    logic [31:0] data;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          t_acc;
    int          t_resp;
  } exp_t;

  typedef struct {
    logic is_ifu;
    int   cyc;
  } acc_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   model_en = 1'b0;
  bit   rand_rr = 1'b0;
  bit   mem_init = 1'b1;
  logic pref_ifu = 1'b0;
  exp_t exp_q[$];
  acc_t acc_log[$];
  logic [31:0] last_ifu_data, last_lsu_data;
  logic        last_ifu_err, last_lsu_err;
  int          lsu_pop_cyc = -1;

  logic [7:0]  mem [0:255];
  logic [7:0]  ref_mem [0:255];
  logic [7:0]  mem_a;

  function automatic logic [7:0] init_byte(int i);
    logic [31:0] w;
    w = 32'h00A00093;
    if (i >= 16 && i < 20) return w[8*(i-16) +: 8];
    return 8'(i * 37 + 5);
  endfunction

  // memory environment: LSB-aligned read data with junk in unused upper bits
  always_comb begin
    mem_a = bus.mem_bus_addr[7:0];
    case (bus.mem_bus_rwtyp[1:0])
      2'b00:   bus.mem_bus_rdata = {24'h5A5A5A, mem[mem_a]};
      2'b01:   bus.mem_bus_rdata = {16'hC3C3, mem[mem_a + 8'd1], mem[mem_a]};
      default: bus.mem_bus_rdata = {mem[mem_a + 8'd3], mem[mem_a + 8'd2], mem[mem_a + 8'd1], mem[mem_a]};
    endcase
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_byte(i);
    end else if (bus.mem_bus_wen) begin
      case (bus.mem_bus_rwtyp[1:0])
        2'b00: mem[mem_a] <= bus.mem_bus_wdata[7:0];
        2'b01: begin
          mem[mem_a]        <= bus.mem_bus_wdata[7:0];
          mem[mem_a + 8'd1] <= bus.mem_bus_wdata[15:8];
        end
        default: begin
          mem[mem_a]        <= bus.mem_bus_wdata[7:0];
          mem[mem_a + 8'd1] <= bus.mem_bus_wdata[15:8];
          mem[mem_a + 8'd2] <= bus.mem_bus_wdata[23:16];
          mem[mem_a + 8'd3] <= bus.mem_bus_wdata[31:24];
        end
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference: a transaction is a sized byte access on a flat byte array
  task automatic model_txn(input logic w, input logic [2:0] t, input logic [31:0] a,
                           input logic [31:0] d, output logic err, output logic [31:0] data);
    int     n;
    longint v;
    n    = 1 << t[1:0];
    err  = (t[1:0] == 2'b11) || ((a % n) != 0);
    data = 32'd0;
    if (!err) begin
      if (w) begin
        for (int i = 0; i < n; i++) ref_mem[8'(a + i)] = 8'(d >> (8 * i));
      end else begin
        v = 0;
        for (int i = 0; i < n; i++) v += longint'(ref_mem[8'(a + i)]) << (8 * i);
        if (!t[2] && n < 4 && v >= (64'sd1 << (8 * n - 1))) v -= (64'sd1 << (8 * n));
        data = 32'(v);
      end
    end
  endtask

  exp_t m_e;
  logic m_eir, m_elr, m_ov, m_xv, m_oe, m_ordy;
  logic [31:0] m_od;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (model_en && rstn) begin
      if (exp_q.size() == 0) begin
        m_eir = bus.ifu_req_valid && (!bus.lsu_req_valid || pref_ifu);
        m_elr = bus.lsu_req_valid && !m_eir;
        chk("ifu_req_ready", bus.ifu_req_ready, m_eir);
        chk("lsu_req_ready", bus.lsu_req_ready, m_elr);
        chk("idle_mem_wen", bus.mem_bus_wen, 0);
        chk("idle_resp_valid", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 0);
        if (m_eir || m_elr) begin
          m_e.is_ifu = m_eir;
          if (m_eir) begin
            m_e.addr = bus.ifu_req_addr; m_e.wdata = 0;
            model_txn(1'b0, 3'b010, bus.ifu_req_addr, 32'd0, m_e.err, m_e.data);
            m_e.wen = 1'b0;
          end else begin
            m_e.addr = bus.lsu_req_addr; m_e.wdata = bus.lsu_req_wdata;
            model_txn(bus.lsu_req_wen, bus.lsu_req_rwtyp, bus.lsu_req_addr,
                      bus.lsu_req_wdata, m_e.err, m_e.data);
            m_e.wen = bus.lsu_req_wen && !m_e.err;
          end
          m_e.t_acc  = m_e.err ? -1 : cyc + 1;
          m_e.t_resp = cyc + (m_e.err ? 1 : 2);
          exp_q.push_back(m_e);
          acc_log.push_back('{is_ifu: m_eir, cyc: cyc});
          pref_ifu = !m_eir;
        end
      end else begin
        m_e = exp_q[0];
        chk("busy_req_ready", {bus.ifu_req_ready, bus.lsu_req_ready}, 0);
        chk("mem_bus_wen", bus.mem_bus_wen, (cyc == m_e.t_acc) && m_e.wen);
        if (cyc == m_e.t_acc) begin
          chk("mem_bus_addr", bus.mem_bus_addr, m_e.addr);
          if (m_e.wen) chk("mem_bus_wdata", bus.mem_bus_wdata, m_e.wdata);
        end
        m_ov   = m_e.is_ifu ? bus.ifu_resp_valid : bus.lsu_resp_valid;
        m_xv   = m_e.is_ifu ? bus.lsu_resp_valid : bus.ifu_resp_valid;
        m_od   = m_e.is_ifu ? bus.ifu_resp_data  : bus.lsu_resp_rdata;
        m_oe   = m_e.is_ifu ? bus.ifu_resp_err   : bus.lsu_resp_err;
        m_ordy = m_e.is_ifu ? bus.ifu_resp_ready : bus.lsu_resp_ready;
        chk("other_resp_valid", m_xv, 0);
        chk("resp_valid", m_ov, cyc >= m_e.t_resp);
        if (m_ov) begin
          chk(m_e.is_ifu ? "ifu_resp_data" : "lsu_resp_rdata", m_od, m_e.data);
          chk(m_e.is_ifu ? "ifu_resp_err" : "lsu_resp_err", m_oe, m_e.err);
          if (m_ordy) begin
            void'(exp_q.pop_front());
            if (m_e.is_ifu) begin
              last_ifu_data = m_od; last_ifu_err = m_oe;
            end else begin
              last_lsu_data = m_od; last_lsu_err = m_oe; lsu_pop_cyc = cyc;
            end
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rr) begin
      #1;
      bus.ifu_resp_ready = 1'($urandom_range(0, 1));
      bus.lsu_resp_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic ifu_issue(input logic [31:0] a);
    bit got = 0;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = a;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      got = bus.ifu_req_ready;
    end
    @(posedge clk); #1;
    bus.ifu_req_valid = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL ifu_accept: not accepted within 300 cycles, addr 0x%08h", a);
    end
  endtask

  task automatic lsu_issue(input logic w, input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
    bit got = 0;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_req_wen   = w;
    bus.lsu_req_rwtyp = t;
    bus.lsu_req_addr  = a;
    bus.lsu_req_wdata = d;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      got = bus.lsu_req_ready;
    end
    @(posedge clk); #1;
    bus.lsu_req_valid = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL lsu_accept: not accepted within 300 cycles, addr 0x%08h", a);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    chk("drain_pending", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    model_en = 1'b0;
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    exp_q.delete();
    acc_log.delete();
    pref_ifu = 1'b0;
    rstn = 1'b1;
    @(posedge clk); #1;
    model_en = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] orig;

  initial begin
    rstn = 1'b0;
    bus.ifu_req_valid = 0; bus.ifu_req_addr = 0; bus.ifu_resp_ready = 1;
    bus.lsu_req_valid = 0; bus.lsu_req_wen = 0; bus.lsu_req_rwtyp = 0;
    bus.lsu_req_addr = 0; bus.lsu_req_wdata = 0; bus.lsu_resp_ready = 1;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_init = 1'b0;
    chk("rst_ifu_resp_valid", bus.ifu_resp_valid, 0);
    chk("rst_lsu_resp_valid", bus.lsu_resp_valid, 0);
    chk("rst_mem_bus_wen", bus.mem_bus_wen, 0);
    chk("rst_mem_bus_addr", bus.mem_bus_addr, 0);
    chk("rst_req_ready", {bus.ifu_req_ready, bus.lsu_req_ready}, 0);
    chk("rst_resp_data", bus.ifu_resp_data | bus.lsu_resp_rdata, 0);
    rstn = 1'b1;
    @(posedge clk); #1;
    model_en = 1'b1;

    ifu_issue(32'h80000010);
    drain();
    chk("ifu_fetch_data", last_ifu_data, 32'h00A00093);
    chk("ifu_fetch_err", last_ifu_err, 0);

    do_reset();
    fork
      begin
        lsu_issue(1'b0, 3'b010, 32'h80000040, 0);
        lsu_issue(1'b0, 3'b010, 32'h80000044, 0);
      end
      begin
        ifu_issue(32'h80000020);
        ifu_issue(32'h80000024);
      end
    join
    drain();
    chk("alt_accepts", acc_log.size(), 4);
    if (acc_log.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("alt_owner", acc_log[k].is_ifu, (k % 2) == 1);
        if (k > 0) chk("alt_spacing", acc_log[k].cyc - acc_log[k-1].cyc, 3);
      end
    end

    lsu_issue(1'b1, 3'b000, 32'h80000003, 32'h000000AB);
    drain();
    chk("store_resp_rdata", last_lsu_data, 0);
    chk("store_mem_byte", mem[3], 8'hAB);
    lsu_issue(1'b0, 3'b000, 32'h80000003, 0);
    drain();
    chk("load_byte_signed", last_lsu_data, 32'hFFFFFFAB);
    lsu_issue(1'b0, 3'b100, 32'h80000003, 0);
    drain();
    chk("load_byte_unsigned", last_lsu_data, 32'h000000AB);

    lsu_issue(1'b0, 3'b001, 32'h80000001, 0);
    drain();
    chk("mis_half_err", last_lsu_err, 1);
    chk("mis_half_data", last_lsu_data, 0);
    ifu_issue(32'h80000002);
    drain();
    chk("mis_ifu_err", last_ifu_err, 1);
    chk("mis_ifu_data", last_ifu_data, 0);

    bus.lsu_resp_ready = 1'b0;
    lsu_issue(1'b0, 3'b010, 32'h80000010, 0);
    fork
      ifu_issue(32'h80000014);
      begin
        repeat (6) @(posedge clk);
        #1 bus.lsu_resp_ready = 1'b1;
      end
    join
    drain();
    chk("bp_last_is_ifu", acc_log[$].is_ifu, 1);
    chk("bp_ifu_accept_cycle", acc_log[$].cyc, lsu_pop_cyc + 1);
    chk("bp_lsu_data", last_lsu_data, 32'h00A00093);

    // abort a store mid-access with reset; memory must keep its old byte
    orig = mem[8];
    lsu_issue(1'b1, 3'b000, 32'h80000008, 32'h00000055);
    model_en = 1'b0;
    chk("abort_wen_before", bus.mem_bus_wen, 1);
    #2 rstn = 1'b0;
    #1 chk("abort_wen_dropped", bus.mem_bus_wen, 0);
    ref_mem[8] = orig;
    exp_q.delete();
    acc_log.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("abort_resp_valid", bus.lsu_resp_valid, 0);
    chk("abort_mem_unchanged", mem[8], orig);
    pref_ifu = 1'b0;
    rstn = 1'b1;
    @(posedge clk); #1;
    model_en = 1'b1;
    fork
      ifu_issue(32'h80000030);
      lsu_issue(1'b0, 3'b010, 32'h80000034, 0);
    join
    drain();
    chk("abort_lsu_first", acc_log.size() > 0 ? acc_log[0].is_ifu : 1'b1, 0);

    rand_rr = 1'b1;
    fork
      begin
        repeat (40) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          ifu_issue(32'h80000000 + $urandom_range(0, 15) * 4 +
                    (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0));
        end
      end
      begin
        repeat (60) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          lsu_issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    32'h80000000 + $urandom_range(0, 60), $urandom);
        end
      end
    join
    rand_rr = 1'b0;
    @(posedge clk); #2;
    bus.ifu_resp_ready = 1'b1;
    bus.lsu_resp_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
